// File: rtl/gcd_arbiter_pkg.sv
// gcd_arb_pkg: shared types and sizing helpers for the GCD arbiter slice.
//   arb_state_e : arbiter FSM encoding
//   idx_w()     : index width for a count of items (never below 1 bit)
//   TO_W        : watchdog width for the default TIMEOUT of 1024; the arbiter
//                 re-derives its own width from its TIMEOUT parameter
package gcd_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TO_W = $clog2(1024);

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 and wraps
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted requester (0 when no request)
module rr_pick
  import gcd_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [idx_w(N)-1:0] idx
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GCD unit among N requesters, one job in flight.
//   clock, reset_n               : clock, async active-low reset
//   req_valid/req_ready/req_x/y  : per-requester job handshake, flat operands
//   resp_valid/resp_ready        : per-requester result handshake
//   resp_bits, resp_err          : shared result; err=1 means watchdog abort
//   gcd_in_*/gcd_out_*           : connection to the GCD datapath unit
//   busy, grant_id               : job in progress and its owner
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*W-1:0]        req_x,
  input  logic [N*W-1:0]        req_y,
  output logic [N-1:0]          resp_valid,
  input  logic [N-1:0]          resp_ready,
  output logic [W-1:0]          resp_bits,
  output logic                  resp_err,
  output logic                  gcd_in_valid,
  input  logic                  gcd_in_ready,
  output logic [W-1:0]          gcd_in_x,
  output logic [W-1:0]          gcd_in_y,
  input  logic                  gcd_out_valid,
  input  logic [W-1:0]          gcd_out_bits,
  output logic                  busy,
  output logic [idx_w(N)-1:0]   grant_id
);

  localparam int IW     = idx_w(N);
  localparam int WDOG_W = idx_w(TIMEOUT);

  arb_state_e        state, state_nxt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     id_q;
  logic [WDOG_W-1:0] wdog;
  logic [W-1:0]      x_q, y_q, res_q;
  logic              err_q;

  logic [N-1:0]      pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              req_hs, issue_hs, wdog_fire, resp_hs;

  rr_pick #(.N(N)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign req_hs    = (state == IDLE) && (|req_valid);
  assign issue_hs  = (state == ISSUE) && gcd_in_ready;
  assign wdog_fire = (wdog == WDOG_W'(TIMEOUT - 1));
  assign resp_hs   = (state == RESP) && resp_ready[id_q];

  // State register and control (async reset)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= IW'(N - 1);
      id_q  <= '0;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      if (req_hs)
        id_q <= pick_idx;
      if (resp_hs)
        ptr <= id_q;
      if (issue_hs)
        wdog <= '0;
      else if (state == WAIT)
        wdog <= wdog + 1'b1;
    end
  end

  // Next-state logic; a result arriving on the timeout cycle still wins
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_hs)                     state_nxt = ISSUE;
      ISSUE: if (gcd_in_ready)               state_nxt = WAIT;
      WAIT:  if (gcd_out_valid || wdog_fire) state_nxt = RESP;
      RESP:  if (resp_ready[id_q])           state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Operand/result registers: data only, qualified by state downstream
  always_ff @(posedge clock) begin
    if (req_hs) begin
      x_q <= req_x[int'(pick_idx)*W +: W];
      y_q <= req_y[int'(pick_idx)*W +: W];
    end
    if (state == WAIT) begin
      if (gcd_out_valid) begin
        res_q <= gcd_out_bits;
        err_q <= 1'b0;
      end else if (wdog_fire) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
    end
  end

  // Outputs; req_ready is also masked while reset is held
  always_comb begin
    req_ready    = ((state == IDLE) && reset_n) ? pick_gnt : '0;
    gcd_in_valid = (state == ISSUE);
    gcd_in_x     = (state == ISSUE) ? x_q : '0;
    gcd_in_y     = (state == ISSUE) ? y_q : '0;
    resp_valid   = (state == RESP) ? (N'(1) << id_q) : '0;
    resp_bits    = (state == RESP) ? res_q : '0;
    resp_err     = (state == RESP) ? err_q : 1'b0;
    busy         = (state != IDLE);
    grant_id     = (state != IDLE) ? id_q : '0;
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
module tb_gcd_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;
  localparam int IW      = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0]   req_x, req_y;
  logic [W-1:0]     resp_bits, gcd_in_x, gcd_in_y, gcd_out_bits;
  logic             resp_err, gcd_in_valid, gcd_in_ready, gcd_out_valid, busy;
  logic [IW-1:0]    grant_id;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] tx [N];
  logic [W-1:0] ty [N];

  gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_y         (req_y),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_bits     (resp_bits),
    .resp_err      (resp_err),
    .gcd_in_valid  (gcd_in_valid),
    .gcd_in_ready  (gcd_in_ready),
    .gcd_in_x      (gcd_in_x),
    .gcd_in_y      (gcd_in_y),
    .gcd_out_valid (gcd_out_valid),
    .gcd_out_bits  (gcd_out_bits),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] x, input logic [W-1:0] y);
    tx[id] = x;
    ty[id] = y;
    req_x[id*W +: W] = x;
    req_y[id*W +: W] = y;
    req_valid[id] = 1'b1;
  endtask

  // GCD stub behaviour: Euclid on whatever the arbiter actually issued
  function automatic logic [W-1:0] gcd_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    for (int i = 0; i < 200 && b != 0; i++) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // One complete job for requester id, starting in IDLE with req_valid[id] set
  task automatic serve(input int id, input logic [W-1:0] exp_res, input int in_stall,
                       input int out_lat, input int rr_hold);
    logic [W-1:0] cx, cy;
    logic [N-1:0] onehot;
    onehot = N'(1) << id;
    #1 check("req_ready_grant", 64'(req_ready), 64'(onehot));
    tick();
    req_valid[id] = 1'b0;
    check("issue_valid", 64'(gcd_in_valid), 64'd1);
    check("issue_x", 64'(gcd_in_x), 64'(tx[id]));
    check("issue_y", 64'(gcd_in_y), 64'(ty[id]));
    check("grant_id", 64'(grant_id), 64'(id));
    check("busy_job", 64'(busy), 64'd1);
    check("req_ready_issue", 64'(req_ready), 64'd0);
    for (int s = 0; s < in_stall; s++) begin
      tick();
      check("stall_valid", 64'(gcd_in_valid), 64'd1);
      check("stall_x", 64'(gcd_in_x), 64'(tx[id]));
      check("stall_y", 64'(gcd_in_y), 64'(ty[id]));
    end
    gcd_in_ready = 1'b1;
    cx = gcd_in_x;
    cy = gcd_in_y;
    tick();
    gcd_in_ready = 1'b0;
    check("wait_in_valid", 64'(gcd_in_valid), 64'd0);
    check("wait_resp_valid", 64'(resp_valid), 64'd0);
    repeat (out_lat) tick();
    gcd_out_valid = 1'b1;
    gcd_out_bits  = gcd_model(cx, cy);
    tick();
    gcd_out_valid = 1'b0;
    gcd_out_bits  = '0;
    check("resp_valid", 64'(resp_valid), 64'(onehot));
    check("resp_bits", 64'(resp_bits), 64'(exp_res));
    check("resp_err", 64'(resp_err), 64'd0);
    check("req_ready_resp", 64'(req_ready), 64'd0);
    for (int h = 0; h < rr_hold; h++) begin
      tick();
      check("hold_valid", 64'(resp_valid), 64'(onehot));
      check("hold_bits", 64'(resp_bits), 64'(exp_res));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = onehot;
    tick();
    resp_ready = '0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_resp_valid", 64'(resp_valid), 64'd0);
    check("idle_resp_bits", 64'(resp_bits), 64'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    req_valid     = '0;
    req_x         = '0;
    req_y         = '0;
    resp_ready    = '0;
    gcd_in_ready  = 1'b0;
    gcd_out_valid = 1'b0;
    gcd_out_bits  = '0;
    repeat (2) tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_bits", 64'(resp_bits), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_gcd_valid", 64'(gcd_in_valid), 64'd0);
    check("rst_gcd_x", 64'(gcd_in_x), 64'd0);
    check("rst_gcd_y", 64'(gcd_in_y), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    reset_n = 1'b1;
    tick();

    // all four requesting: order 0,1,2,3; input stall on job 0, response hold on job 1
    set_req(0, 48, 36);
    set_req(1, 7, 5);
    set_req(2, 100, 75);
    set_req(3, 9, 27);
    serve(0, 12, 2, 0, 0);
    serve(1, 1, 0, 3, 10);
    serve(2, 25, 0, 1, 0);
    serve(3, 9, 0, 0, 0);
    check("no_req_ready", 64'(req_ready), 64'd0);

    // single requester 1
    set_req(1, 12, 18);
    serve(1, 6, 0, 2, 0);

    // after a job from 2, requesters 0 and 3: 3 goes first
    set_req(2, 8, 12);
    serve(2, 4, 0, 0, 0);
    set_req(0, 15, 25);
    set_req(3, 21, 14);
    serve(3, 7, 0, 1, 0);
    serve(0, 5, 0, 1, 0);

    // watchdog: GCD never answers
    set_req(1, 5, 10);
    #1 check("to_req_ready", 64'(req_ready), 64'd2);
    tick();
    req_valid[1] = 1'b0;
    gcd_in_ready = 1'b1;
    tick();
    gcd_in_ready = 1'b0;
    repeat (15) tick();
    check("to_still_wait_busy", 64'(busy), 64'd1);
    check("to_still_wait_resp", 64'(resp_valid), 64'd0);
    tick();
    check("to_resp_valid", 64'(resp_valid), 64'd2);
    check("to_resp_err", 64'(resp_err), 64'd1);
    check("to_resp_bits", 64'(resp_bits), 64'd0);
    gcd_out_valid = 1'b1;
    gcd_out_bits  = 5;
    tick();
    gcd_out_valid = 1'b0;
    gcd_out_bits  = '0;
    check("late_resp_bits", 64'(resp_bits), 64'd0);
    check("late_resp_err", 64'(resp_err), 64'd1);
    check("late_resp_valid", 64'(resp_valid), 64'd2);
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
    check("to_idle_busy", 64'(busy), 64'd0);
    gcd_out_valid = 1'b1;
    gcd_out_bits  = 9;
    tick();
    gcd_out_valid = 1'b0;
    gcd_out_bits  = '0;
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_resp_valid", 64'(resp_valid), 64'd0);

    // reset asserted in WAIT drops the job
    set_req(2, 6, 9);
    #1 check("rw_req_ready", 64'(req_ready), 64'd4);
    tick();
    req_valid[2] = 1'b0;
    gcd_in_ready = 1'b1;
    tick();
    gcd_in_ready = 1'b0;
    tick();
    check("rw_busy", 64'(busy), 64'd1);
    check("rw_grant_id", 64'(grant_id), 64'd2);
    set_req(0, 30, 45);
    set_req(3, 16, 40);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_grant_id", 64'(grant_id), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    check("arst_gcd_valid", 64'(gcd_in_valid), 64'd0);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    tick();
    reset_n = 1'b1;
    serve(0, 15, 0, 0, 0);
    serve(3, 8, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
